// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle for the IFU/LSU memory arbiter: both requester ports plus the shared memory port.
// The arbiter uses the master modport; requesters and memory together form the slave side.
interface riscv_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    ifu_req_valid;
    logic                    ifu_req_ready;
    logic [ADDR_WIDTH-1:0]   ifu_addr;
    logic                    ifu_rsp_valid;
    logic [DATA_WIDTH-1:0]   ifu_rdata;

    logic                    lsu_req_valid;
    logic                    lsu_req_ready;
    logic                    lsu_wen;
    logic [ADDR_WIDTH-1:0]   lsu_addr;
    logic [DATA_WIDTH-1:0]   lsu_wdata;
    logic [DATA_WIDTH/8-1:0] lsu_wmask;
    logic                    lsu_rsp_valid;
    logic [DATA_WIDTH-1:0]   lsu_rdata;

    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic                    mem_wen;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_wmask;
    logic                    mem_rsp_valid;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport master (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
        input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
        output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// with a single latched request slot and at most one transaction outstanding.
module riscv_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    riscv_mem_arbiter_if.master  bus
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    state_t                state;
    owner_t                owner;
    owner_t                last_grant;
    logic                  req_valid_q;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MASK_WIDTH-1:0] wmask_q;

    logic grant_ifu;
    logic grant_lsu;
    logic rsp_fire;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (!rst && state == IDLE) begin
            if (bus.ifu_req_valid && (!bus.lsu_req_valid || last_grant == OWN_LSU))
                grant_ifu = 1'b1;
            else if (bus.lsu_req_valid)
                grant_lsu = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_IFU;
            last_grant  <= OWN_LSU;
            req_valid_q <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ifu || grant_lsu) begin
                        state       <= REQ;
                        req_valid_q <= 1'b1;
                        owner       <= grant_lsu ? OWN_LSU : OWN_IFU;
                        last_grant  <= grant_lsu ? OWN_LSU : OWN_IFU;
                        wen_q       <= grant_lsu && bus.lsu_wen;
                        addr_q      <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
                        wdata_q     <= grant_lsu ? bus.lsu_wdata : '0;
                        wmask_q     <= grant_lsu ? bus.lsu_wmask : '0;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        state       <= RESP;
                        req_valid_q <= 1'b0;
                    end
                end
                RESP: begin
                    if (bus.mem_rsp_valid)
                        state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Responses are only meaningful while waiting for one; anything else from memory is dropped.
    assign rsp_fire = !rst && state == RESP && bus.mem_rsp_valid;

    assign bus.ifu_req_ready = grant_ifu;
    assign bus.lsu_req_ready = grant_lsu;
    assign bus.ifu_rsp_valid = rsp_fire && owner == OWN_IFU;
    assign bus.lsu_rsp_valid = rsp_fire && owner == OWN_LSU;
    assign bus.ifu_rdata     = bus.mem_rdata;
    assign bus.lsu_rdata     = bus.mem_rdata;

    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration and routing rules.
module tb_riscv_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    riscv_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    riscv_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.ifu_req_valid = 1'b0;
        bus.ifu_addr      = '0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_wen       = 1'b0;
        bus.lsu_addr      = '0;
        bus.lsu_wdata     = '0;
        bus.lsu_wmask     = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        vectors++; if (bus.ifu_req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ifu_ready: got %b want 0", bus.ifu_req_ready); end
        vectors++; if (bus.lsu_req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_lsu_ready: got %b want 0", bus.lsu_req_ready); end
        vectors++; if (bus.ifu_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ifu_rsp: got %b want 0", bus.ifu_rsp_valid); end
        vectors++; if (bus.lsu_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_lsu_rsp: got %b want 0", bus.lsu_rsp_valid); end
        vectors++; if (bus.mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_valid: got %b want 0", bus.mem_req_valid); end
        vectors++; if (bus.mem_wen !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_wen: got %b want 0", bus.mem_wen); end
        vectors++; if (bus.mem_addr !== '0) begin miscompares++; $display("[TB] FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        vectors++; if (bus.mem_wdata !== '0) begin miscompares++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
        vectors++; if (bus.mem_wmask !== '0) begin miscompares++; $display("[TB] FAIL reset_mem_wmask: got %h want 0", bus.mem_wmask); end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_ifu_fetch();
        do_reset();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0000;
        bus.mem_req_ready = 1'b1;
        #1;
        vectors++; if (bus.ifu_req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL fetch_c0_ifu_ready: got %b want 1", bus.ifu_req_ready); end
        vectors++; if (bus.lsu_req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch_c0_lsu_ready: got %b want 0", bus.lsu_req_ready); end
        next_cycle();
        bus.ifu_req_valid = 1'b0;
        #1;
        vectors++; if (bus.mem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL fetch_c1_mem_valid: got %b want 1", bus.mem_req_valid); end
        vectors++; if (bus.mem_addr !== 32'h8000_0000) begin miscompares++; $display("[TB] FAIL fetch_c1_mem_addr: got %h want 80000000", bus.mem_addr); end
        vectors++; if (bus.mem_wen !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch_c1_mem_wen: got %b want 0", bus.mem_wen); end
        vectors++; if (bus.mem_wmask !== '0) begin miscompares++; $display("[TB] FAIL fetch_c1_mem_wmask: got %h want 0", bus.mem_wmask); end
        vectors++; if (bus.ifu_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch_c1_ifu_rsp: got %b want 0", bus.ifu_rsp_valid); end
        next_cycle();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h0000_0413;
        #1;
        vectors++; if (bus.ifu_rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL fetch_c2_ifu_rsp: got %b want 1", bus.ifu_rsp_valid); end
        vectors++; if (bus.ifu_rdata !== 32'h0000_0413) begin miscompares++; $display("[TB] FAIL fetch_c2_ifu_rdata: got %h want 00000413", bus.ifu_rdata); end
        vectors++; if (bus.lsu_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch_c2_lsu_rsp: got %b want 0", bus.lsu_rsp_valid); end
        next_cycle();
        bus.mem_rsp_valid = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0004;
        #1;
        vectors++; if (bus.ifu_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch_c3_ifu_rsp: got %b want 0", bus.ifu_rsp_valid); end
        vectors++; if (bus.ifu_req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL fetch_c3_next_accept: got %b want 1", bus.ifu_req_ready); end
        idle_inputs();
    endtask

    task automatic test_store_backpressure();
        int pulses;
        do_reset();
        bus.lsu_req_valid = 1'b1;
        bus.lsu_wen       = 1'b1;
        bus.lsu_addr      = 32'h8000_1000;
        bus.lsu_wdata     = 32'hDEAD_BEEF;
        bus.lsu_wmask     = 4'hF;
        #1;
        vectors++; if (bus.lsu_req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL store_lsu_ready: got %b want 1", bus.lsu_req_ready); end
        vectors++; if (bus.ifu_req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL store_ifu_ready: got %b want 0", bus.ifu_req_ready); end
        next_cycle();
        bus.lsu_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.lsu_addr      = $urandom;
            bus.lsu_wdata     = $urandom;
            bus.lsu_wmask     = MW'($urandom);
            bus.mem_req_ready = (i == 3);
            #1;
            vectors++; if (bus.mem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL store_hold%0d_valid: got %b want 1", i, bus.mem_req_valid); end
            vectors++; if (bus.mem_wen !== 1'b1) begin miscompares++; $display("[TB] FAIL store_hold%0d_wen: got %b want 1", i, bus.mem_wen); end
            vectors++; if (bus.mem_addr !== 32'h8000_1000) begin miscompares++; $display("[TB] FAIL store_hold%0d_addr: got %h want 80001000", i, bus.mem_addr); end
            vectors++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL store_hold%0d_wdata: got %h want deadbeef", i, bus.mem_wdata); end
            vectors++; if (bus.mem_wmask !== 4'hF) begin miscompares++; $display("[TB] FAIL store_hold%0d_wmask: got %h want f", i, bus.mem_wmask); end
            next_cycle();
        end
        bus.mem_req_ready = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_rsp_valid = (i == 2);
            bus.mem_rdata     = $urandom;
            #1;
            if (bus.lsu_rsp_valid === 1'b1) pulses++;
            vectors++; if (bus.lsu_rsp_valid !== (i == 2)) begin miscompares++; $display("[TB] FAIL store_rsp%0d_lsu: got %b want %b", i, bus.lsu_rsp_valid, (i == 2)); end
            vectors++; if (bus.ifu_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL store_rsp%0d_ifu: got %b want 0", i, bus.ifu_rsp_valid); end
            vectors++; if (bus.mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL store_rsp%0d_mem_valid: got %b want 0", i, bus.mem_req_valid); end
            next_cycle();
        end
        vectors++; if (pulses != 1) begin miscompares++; $display("[TB] FAIL store_pulse_count: got %0d want 1", pulses); end
        idle_inputs();
    endtask

    task automatic test_contention();
        bit          last_lsu;
        bit          exp_lsu;
        logic [DW-1:0] rd;
        do_reset();
        last_lsu          = 1'b1;
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h0000_1000;
        bus.lsu_addr      = 32'h0000_2000;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_lsu  = !last_lsu;
            last_lsu = exp_lsu;
            #1;
            vectors++; if (bus.ifu_req_ready !== !exp_lsu) begin miscompares++; $display("[TB] FAIL contend%0d_ifu_ready: got %b want %b", t, bus.ifu_req_ready, !exp_lsu); end
            vectors++; if (bus.lsu_req_ready !== exp_lsu) begin miscompares++; $display("[TB] FAIL contend%0d_lsu_ready: got %b want %b", t, bus.lsu_req_ready, exp_lsu); end
            vectors++; if ((bus.ifu_rsp_valid | bus.lsu_rsp_valid) !== 1'b0) begin miscompares++; $display("[TB] FAIL contend%0d_idle_rsp: got %b%b want 00", t, bus.ifu_rsp_valid, bus.lsu_rsp_valid); end
            next_cycle();
            #1;
            vectors++; if (bus.mem_addr !== (exp_lsu ? 32'h0000_2000 : 32'h0000_1000)) begin miscompares++; $display("[TB] FAIL contend%0d_mem_addr: got %h want %h", t, bus.mem_addr, (exp_lsu ? 32'h0000_2000 : 32'h0000_1000)); end
            vectors++; if ((bus.ifu_rsp_valid | bus.lsu_rsp_valid) !== 1'b0) begin miscompares++; $display("[TB] FAIL contend%0d_req_rsp: got %b%b want 00", t, bus.ifu_rsp_valid, bus.lsu_rsp_valid); end
            next_cycle();
            rd = $urandom;
            bus.mem_rdata = rd;
            #1;
            vectors++; if (bus.ifu_rsp_valid !== !exp_lsu) begin miscompares++; $display("[TB] FAIL contend%0d_ifu_rsp: got %b want %b", t, bus.ifu_rsp_valid, !exp_lsu); end
            vectors++; if (bus.lsu_rsp_valid !== exp_lsu) begin miscompares++; $display("[TB] FAIL contend%0d_lsu_rsp: got %b want %b", t, bus.lsu_rsp_valid, exp_lsu); end
            vectors++; if ((exp_lsu ? bus.lsu_rdata : bus.ifu_rdata) !== rd) begin miscompares++; $display("[TB] FAIL contend%0d_rdata: got %h want %h", t, (exp_lsu ? bus.lsu_rdata : bus.ifu_rdata), rd); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_spurious();
        do_reset();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h1234_5678;
        #1;
        vectors++; if ((bus.ifu_rsp_valid | bus.lsu_rsp_valid) !== 1'b0) begin miscompares++; $display("[TB] FAIL spur_idle_rsp: got %b%b want 00", bus.ifu_rsp_valid, bus.lsu_rsp_valid); end
        next_cycle();
        #1;
        vectors++; if (bus.mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL spur_idle_state: got mem_req_valid %b want 0", bus.mem_req_valid); end
        vectors++; if ((bus.ifu_rsp_valid | bus.lsu_rsp_valid) !== 1'b0) begin miscompares++; $display("[TB] FAIL spur_idle_rsp2: got %b%b want 00", bus.ifu_rsp_valid, bus.lsu_rsp_valid); end
        bus.mem_rsp_valid = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0100;
        #1;
        vectors++; if (bus.ifu_req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL spur_accept: got %b want 1", bus.ifu_req_ready); end
        next_cycle();
        bus.ifu_req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.mem_rsp_valid = 1'b1;
            #1;
            vectors++; if ((bus.ifu_rsp_valid | bus.lsu_rsp_valid) !== 1'b0) begin miscompares++; $display("[TB] FAIL spur_req%0d_rsp: got %b%b want 00", i, bus.ifu_rsp_valid, bus.lsu_rsp_valid); end
            vectors++; if (bus.mem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL spur_req%0d_hold: got %b want 1", i, bus.mem_req_valid); end
            next_cycle();
        end
        bus.mem_rsp_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        #1;
        vectors++; if (bus.mem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL spur_req_final: got %b want 1", bus.mem_req_valid); end
        next_cycle();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'hCAFE_0001;
        #1;
        vectors++; if (bus.ifu_rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL spur_real_rsp: got %b want 1", bus.ifu_rsp_valid); end
        vectors++; if (bus.ifu_rdata !== 32'hCAFE_0001) begin miscompares++; $display("[TB] FAIL spur_real_rdata: got %h want cafe0001", bus.ifu_rdata); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] rd;
        do_reset();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0010;
        bus.mem_req_ready = 1'b1;
        #1;
        vectors++; if (bus.ifu_req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_accept: got %b want 1", bus.ifu_req_ready); end
        next_cycle();
        bus.ifu_req_valid = 1'b0;
        #1;
        vectors++; if (bus.mem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_req: got %b want 1", bus.mem_req_valid); end
        next_cycle();
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        vectors++; if ((bus.ifu_rsp_valid | bus.lsu_rsp_valid) !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_in_reset_rsp: got %b%b want 00", bus.ifu_rsp_valid, bus.lsu_rsp_valid); end
        next_cycle();
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        #1;
        vectors++; if (bus.mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_mem_valid: got %b want 0", bus.mem_req_valid); end
        vectors++; if (bus.mem_addr !== '0) begin miscompares++; $display("[TB] FAIL rmid_mem_addr: got %h want 0", bus.mem_addr); end
        vectors++; if (bus.mem_wen !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_mem_wen: got %b want 0", bus.mem_wen); end
        vectors++; if ((bus.ifu_rsp_valid | bus.lsu_rsp_valid) !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_late_rsp: got %b%b want 00", bus.ifu_rsp_valid, bus.lsu_rsp_valid); end
        next_cycle();
        bus.mem_rsp_valid = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0020;
        #1;
        vectors++; if (bus.ifu_req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_new_ifu_ready: got %b want 1", bus.ifu_req_ready); end
        vectors++; if (bus.lsu_req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_new_lsu_ready: got %b want 0", bus.lsu_req_ready); end
        next_cycle();
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        #1;
        vectors++; if (bus.mem_addr !== 32'h8000_0020) begin miscompares++; $display("[TB] FAIL rmid_new_addr: got %h want 80000020", bus.mem_addr); end
        next_cycle();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        rd = $urandom;
        bus.mem_rdata = rd;
        #1;
        vectors++; if (bus.ifu_rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_new_rsp: got %b want 1", bus.ifu_rsp_valid); end
        vectors++; if (bus.ifu_rdata !== rd) begin miscompares++; $display("[TB] FAIL rmid_new_rdata: got %h want %h", bus.ifu_rdata, rd); end
        next_cycle();
        idle_inputs();
    endtask

    // Transaction-level model: a slot that is empty, waiting on memory acceptance, or waiting on data.
    task automatic test_random();
        bit            busy;
        bit            accepted;
        bit            own_lsu;
        bit            last_lsu;
        bit            g_ifu;
        bit            g_lsu;
        bit            exp_ifu_rsp;
        bit            exp_lsu_rsp;
        bit            exp_mem_valid;
        logic [AW-1:0] cur_addr;
        logic [DW-1:0] cur_wdata;
        logic [MW-1:0] cur_wmask;
        bit            cur_wen;
        do_reset();
        busy      = 1'b0;
        accepted  = 1'b0;
        own_lsu   = 1'b0;
        last_lsu  = 1'b1;
        cur_addr  = '0;
        cur_wdata = '0;
        cur_wmask = '0;
        cur_wen   = 1'b0;
        for (int c = 0; c < 600; c++) begin
            bus.ifu_req_valid = 1'($urandom_range(0, 1));
            bus.lsu_req_valid = 1'($urandom_range(0, 1));
            bus.ifu_addr      = $urandom;
            bus.lsu_addr      = $urandom;
            bus.lsu_wen       = 1'($urandom_range(0, 1));
            bus.lsu_wdata     = $urandom;
            bus.lsu_wmask     = MW'($urandom);
            bus.mem_req_ready = ($urandom_range(0, 2) != 0);
            bus.mem_rsp_valid = ($urandom_range(0, 2) != 0);
            bus.mem_rdata     = $urandom;
            #1;
            g_ifu         = !busy && bus.ifu_req_valid && (!bus.lsu_req_valid || last_lsu);
            g_lsu         = !busy && bus.lsu_req_valid && !g_ifu;
            exp_mem_valid = busy && !accepted;
            exp_ifu_rsp   = busy && accepted && bus.mem_rsp_valid && !own_lsu;
            exp_lsu_rsp   = busy && accepted && bus.mem_rsp_valid && own_lsu;
            vectors++; if (bus.ifu_req_ready !== g_ifu) begin miscompares++; $display("[TB] FAIL rand%0d_ifu_ready: got %b want %b", c, bus.ifu_req_ready, g_ifu); end
            vectors++; if (bus.lsu_req_ready !== g_lsu) begin miscompares++; $display("[TB] FAIL rand%0d_lsu_ready: got %b want %b", c, bus.lsu_req_ready, g_lsu); end
            vectors++; if (bus.ifu_rsp_valid !== exp_ifu_rsp) begin miscompares++; $display("[TB] FAIL rand%0d_ifu_rsp: got %b want %b", c, bus.ifu_rsp_valid, exp_ifu_rsp); end
            vectors++; if (bus.lsu_rsp_valid !== exp_lsu_rsp) begin miscompares++; $display("[TB] FAIL rand%0d_lsu_rsp: got %b want %b", c, bus.lsu_rsp_valid, exp_lsu_rsp); end
            vectors++; if (bus.mem_req_valid !== exp_mem_valid) begin miscompares++; $display("[TB] FAIL rand%0d_mem_valid: got %b want %b", c, bus.mem_req_valid, exp_mem_valid); end
            if (exp_mem_valid) begin
                vectors++; if (bus.mem_addr !== cur_addr) begin miscompares++; $display("[TB] FAIL rand%0d_mem_addr: got %h want %h", c, bus.mem_addr, cur_addr); end
                vectors++; if (bus.mem_wen !== cur_wen) begin miscompares++; $display("[TB] FAIL rand%0d_mem_wen: got %b want %b", c, bus.mem_wen, cur_wen); end
                vectors++; if (bus.mem_wmask !== cur_wmask) begin miscompares++; $display("[TB] FAIL rand%0d_mem_wmask: got %h want %h", c, bus.mem_wmask, cur_wmask); end
                if (own_lsu) begin
                    vectors++; if (bus.mem_wdata !== cur_wdata) begin miscompares++; $display("[TB] FAIL rand%0d_mem_wdata: got %h want %h", c, bus.mem_wdata, cur_wdata); end
                end
            end
            if (exp_ifu_rsp) begin
                vectors++; if (bus.ifu_rdata !== bus.mem_rdata) begin miscompares++; $display("[TB] FAIL rand%0d_ifu_rdata: got %h want %h", c, bus.ifu_rdata, bus.mem_rdata); end
            end
            if (exp_lsu_rsp) begin
                vectors++; if (bus.lsu_rdata !== bus.mem_rdata) begin miscompares++; $display("[TB] FAIL rand%0d_lsu_rdata: got %h want %h", c, bus.lsu_rdata, bus.mem_rdata); end
            end
            if (g_ifu || g_lsu) begin
                busy      = 1'b1;
                accepted  = 1'b0;
                own_lsu   = g_lsu;
                last_lsu  = g_lsu;
                cur_addr  = g_lsu ? bus.lsu_addr : bus.ifu_addr;
                cur_wen   = g_lsu && bus.lsu_wen;
                cur_wmask = g_lsu ? bus.lsu_wmask : '0;
                cur_wdata = bus.lsu_wdata;
            end else if (busy && !accepted && bus.mem_req_ready) begin
                accepted = 1'b1;
            end else if (busy && accepted && bus.mem_rsp_valid) begin
                busy = 1'b0;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_ifu_fetch();
        test_store_backpressure();
        test_contention();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
